// File: rtl/rf_access_ctrl.sv
// Register-file port-ownership controller: pipeline traffic passes through by default;
// a debug request halts and drains the pipeline, then takes the RF for one read, write or clear.
module rf_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  cpu_rR1,
    input  logic [4:0]  cpu_rR2,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_wR,
    input  logic [31:0] cpu_wD,
    input  logic        cpu_idle,
    output logic        cpu_halt,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic        dbg_clr,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic [4:0]  rf_rR1,
    output logic [4:0]  rf_rR2,
    input  logic [31:0] rf_rD1,
    output logic        rf_we,
    output logic [4:0]  rf_wR,
    output logic [31:0] rf_wD
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HALT   = 3'd1,
        S_ACCESS = 3'd2,
        S_CLEAR  = 3'd3,
        S_ACK    = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           wr_q;
    logic           clr_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  cnt_q;
    logic           dbg_own;

    assign dbg_own = (state != S_IDLE) && (state != S_HALT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (dbg_clr || dbg_req) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (cpu_idle) begin
                    state_nxt = clr_q ? S_CLEAR : S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_ACK;
            S_CLEAR: begin
                if (cnt_q == AW'(31)) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: state_nxt = S_HOLD;
            S_HOLD: begin
                if (!dbg_req) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // RF port muxes: pipeline owns the ports in IDLE/HALT, debug otherwise
    always_comb begin
        rf_rR1 = cpu_rR1;
        rf_rR2 = cpu_rR2;
        rf_we  = cpu_we;
        rf_wR  = cpu_wR;
        rf_wD  = cpu_wD;
        if (dbg_own) begin
            rf_rR1 = addr_q;
            rf_we  = 1'b0;
            rf_wR  = addr_q;
            rf_wD  = '0;
            case (state)
                S_ACCESS: begin
                    if (wr_q) begin
                        rf_we = (addr_q != '0);
                        rf_wD = dbg_wdata;
                    end
                end
                S_CLEAR: begin
                    rf_we = 1'b1;
                    rf_wR = cnt_q;
                end
                default: ;
            endcase
        end
    end

    // Request latches, clear counter and registered debug/pipeline outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q      <= 1'b0;
            clr_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= AW'(1);
            cpu_halt  <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
            dbg_err   <= 1'b0;
        end else begin
            if (state == S_IDLE && state_nxt == S_HALT) begin
                wr_q   <= dbg_wr;
                clr_q  <= dbg_clr;
                addr_q <= dbg_addr;
            end
            if (state == S_CLEAR) begin
                cnt_q <= (cnt_q == AW'(31)) ? AW'(1) : cnt_q + AW'(1);
            end
            cpu_halt <= (state_nxt != S_IDLE);
            dbg_ack  <= (state_nxt == S_ACK);
            if (state == S_ACCESS && !wr_q) begin
                dbg_rdata <= DW'(rf_rD1);
            end
            if (dbg_own && cpu_we) begin
                dbg_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Port-ownership controller between the pipeline and the 32×32 register file (RF). It passes pipeline read and write-back traffic through to the RF by default. On a debug-host request it halts the pipeline, waits for the pipeline to drain, then takes the RF ports for one read, one write, or a full clear of x1–x31. When the debug access finishes, ownership returns to the pipeline.

## Interface
- No parameters; RF geometry fixed at 32 entries × 32 bits, 5-bit indices.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_rR1, cpu_rR2  in  5  pipeline read indices
- cpu_we  in  1  pipeline write-back enable
- cpu_wR  in  5  pipeline write-back index
- cpu_wD  in  32  pipeline write-back data
- cpu_idle  in  1  pipeline drained (no instruction past ID), valid while cpu_halt=1
- cpu_halt  out  1  stall request to pipeline
- dbg_req  in  1  debug access request, level
- dbg_wr  in  1  1=write, 0=read; sampled with dbg_req
- dbg_clr  in  1  clear-all request, pulse, sampled in IDLE
- dbg_addr  in  5  debug register index
- dbg_wdata  in  32  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  32  last debug read value
- dbg_err  out  1  sticky: pipeline write dropped while debug owned RF
- rf_rR1, rf_rR2  out  5  RF read indices
- rf_rD1  in  32  RF read data port 1
- rf_we  out  1  RF write enable
- rf_wR  out  5  RF write index
- rf_wD  out  32  RF write data

## Operation
- States: IDLE, HALT, ACCESS, CLEAR, ACK, HOLD.
- IDLE
  - dbg_clr=1 → HALT with clear flag set. dbg_clr wins over a simultaneous dbg_req.
  - Else dbg_req=1 → HALT with clear flag=0.
  - dbg_wr and dbg_addr are latched on the IDLE→HALT edge.
- HALT
  - cpu_halt=1; RF ports still carry pipeline traffic so in-flight write-backs complete.
  - cpu_idle=1 → CLEAR if clear flag, else ACCESS.
- ACCESS (1 cycle)
  - Read: rf_rR1=latched addr; rf_rD1 captured into dbg_rdata at the cycle end.
  - Write: rf_we=1, rf_wR=addr, rf_wD=dbg_wdata. A write to addr 0 forces rf_we=0.
  - Next state ACK.
- CLEAR
  - 5-bit counter starts at 1; each cycle rf_we=1, rf_wR=cnt, rf_wD=0.
  - After cnt=31 is written → ACK. x0 is never written.
- ACK (1 cycle): dbg_ack=1 → HOLD.
- HOLD: cpu_halt stays 1 until dbg_req=0, then → IDLE. A new request needs dbg_req low for at least one cycle.
- Port ownership
  - IDLE/HALT: rf_* equal the cpu_* signals.
  - ACCESS/CLEAR/ACK/HOLD: cpu_we is gated off and rf_rR1 follows the debug index (ACCESS only; otherwise the latched addr). rf_rR2 always equals cpu_rR2.
- dbg_err is set when cpu_we=1 in any debug-owned state. It clears only on reset.
- cpu_halt=1 in HALT, ACCESS, CLEAR, ACK, HOLD.

## Timing
- Reset (asynchronous, immediate, including mid-CLEAR or mid-ACCESS)
  - State IDLE, counter 1, latches 0.
  - cpu_halt=0, dbg_ack=0, dbg_rdata=0, dbg_err=0, rf_we=0.
  - RF contents partially cleared by an aborted CLEAR are left as-is.
- Request to halt: cpu_halt rises the cycle after dbg_req/dbg_clr is sampled.
- Read/write latency: cpu_idle sampled high → ACCESS next cycle → dbg_ack one cycle later → dbg_rdata valid with dbg_ack and held until the next read.
- Clear latency: 31 CLEAR cycles, then dbg_ack.
- Minimum halt window
  - Read/write: 4 cycles (HALT, ACCESS, ACK, HOLD) with cpu_idle=1 immediately and dbg_req dropped in ACK.
  - Clear: 34 cycles.
- dbg_req dropped before ACK: the transaction still completes and ACK still pulses. HOLD then exits after 1 cycle.
- dbg_clr asserted outside IDLE is ignored.
- All outputs are registered except the rf_* muxes, which are combinational from state and inputs.

## Test plan
- Pass-through: with no debug activity, cpu_we=1, cpu_wR=5, cpu_wD=0xDEADBEEF → rf_we=1, rf_wR=5, rf_wD=0xDEADBEEF in the same cycle; cpu_halt stays 0.
- Debug read: preload x7=0x12345678; dbg_req=1, dbg_wr=0, dbg_addr=7, cpu_idle=1 → cpu_halt next cycle, dbg_ack 3 cycles after req, dbg_rdata=0x12345678.
- Debug write with drain: cpu_idle held low 5 cycles while the pipeline writes x3=0xA5 → that write lands. Then dbg write x3=0x55 → x3=0x55. A dbg write to x0 → rf_we=0, x0 stays 0.
- Clear-all: fill x1–x31 nonzero; pulse dbg_clr with dbg_req=1 → 31 consecutive rf_we pulses, indices 1..31, data 0; dbg_ack once; all reads return 0.
- Violation and reset: cpu_we=1 during CLEAR → write dropped, dbg_err=1 and sticky. Assert rst at CLEAR cnt=10 → all outputs at reset values; x1–x9 read 0 and x10–x31 keep their old values.
